// File: rtl/fabric_fifo_pkg.sv
// Shared width helpers and mode encoding for the fabric FIFO.
// Pointer widths never drop below one bit.
package fabric_fifo_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_BYP  = 1'b1
  } mode_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fabric_fifo_ptr.sv
// Modulo-DEPTH wrap-around pointer used for FIFO head and tail.
// Advances by one per enabled cycle, wrapping DEPTH-1 back to 0.
module fabric_fifo_ptr #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_adv,
  output logic [W-1:0] o_ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fabric_fifo.sv
// Synchronous valid/ready FIFO with registered storage and an optional
// combinational bypass that freezes the stored contents while active.
module fabric_fifo
  import fabric_fifo_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0,
  parameter int BYPASSABLE = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_data,
  input  logic [((BYPASSABLE > 1) ? BYPASSABLE : 1)-1:0] cfg_data
);

  localparam int PW    = DATA_WIDTH + TAG_WIDTH;
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PW-1:0]    r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  mode_e            w_mode;

  assign w_mode  = ((BYPASSABLE != 0) && cfg_data[0]) ? MODE_BYP
                                                      : MODE_FIFO;
  assign w_full  = (r_cnt == FULL);
  assign w_empty = (r_cnt == '0);

  // Bypass must not move any state, so both strobes are gated by mode.
  assign w_push = in_valid & ~w_full & (w_mode == MODE_FIFO);
  assign w_pop  = out_ready & ~w_empty & (w_mode == MODE_FIFO);

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = r_mem[w_head];
    unique case (w_mode)
      MODE_BYP: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
      end
      MODE_FIFO: begin
        in_ready  = ~w_full;
        out_valid = ~w_empty;
      end
      default: ;
    endcase
  end

  fabric_fifo_ptr #(
    .DEPTH (DEPTH),
    .W     (PTR_W)
  ) u_head (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_pop),
    .o_ptr (w_head)
  );

  fabric_fifo_ptr #(
    .DEPTH (DEPTH),
    .W     (PTR_W)
  ) u_tail (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_push),
    .o_ptr (w_tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_fabric_fifo.sv
// Bench for fabric_fifo: table vectors, directed corners and random
// traffic against a queue model on a DEPTH=5 and a DEPTH=1 instance.
module tb_fabric_fifo;

  localparam int AD  = 5;
  localparam int ADW = 16;
  localparam int AT  = 4;
  localparam int AP  = ADW + AT;
  localparam int BD  = 1;
  localparam int BDW = 8;
  localparam int BP  = BDW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_iv, a_ir, a_ov, a_or;
  logic [AP-1:0] a_id, a_od;
  logic [0:0]    a_cfg;
  logic          b_iv, b_ir, b_ov, b_or;
  logic [BP-1:0] b_id, b_od;
  logic [0:0]    b_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  fabric_fifo #(
    .DEPTH(AD), .DATA_WIDTH(ADW), .TAG_WIDTH(AT), .BYPASSABLE(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .cfg_data(a_cfg)
  );

  fabric_fifo #(
    .DEPTH(BD), .DATA_WIDTH(BDW), .TAG_WIDTH(0), .BYPASSABLE(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .cfg_data(b_cfg)
  );

  typedef struct {
    logic          iv;
    logic          orr;
    logic          cfg;
    logic [AP-1:0] d;
    logic          e_ir;
    logic          e_ov;
    logic          chk_d;
    logic [AP-1:0] e_od;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; a_id = '0; a_cfg = 1'b0;
    b_iv = 1'b0; b_or = 1'b0; b_id = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic run_random(input int sel, input int depth,
                            input int pw, input logic [31:0] seed);
    logic [31:0] q[$];
    logic [31:0] x, cur, mask, od, expd;
    logic        iv, orr, ov, ir;
    int          sent, got, cyc;
    x    = seed;
    mask = (32'd1 << pw) - 32'd1;
    x    = x * 32'd1664525 + 32'd1013904223;
    cur  = (x >> 8) & mask;
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 4000) begin
      iv  = (sent < 100) && ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      if (sel == 0) begin
        a_iv = iv; a_or = orr; a_id = AP'(cur);
      end else begin
        b_iv = iv; b_or = orr; b_id = BP'(cur);
      end
      @(negedge clk);
      ov = (sel == 0) ? a_ov : b_ov;
      ir = (sel == 0) ? a_ir : b_ir;
      od = (sel == 0) ? 32'(a_od) : 32'(b_od);
      chk("rnd_ov", 32'(ov), 32'(q.size() > 0));
      chk("rnd_ir", 32'(ir), 32'(q.size() < depth));
      if (ov && orr && q.size() > 0) begin
        expd = q.pop_front();
        chk("rnd_data", od, expd);
        got++;
      end
      if (iv && ir) begin
        q.push_back(cur);
        sent++;
        x   = x * 32'd1664525 + 32'd1013904223;
        cur = (x >> 8) & mask;
      end
      step();
      cyc++;
    end
    chk("rnd_count", 32'(got), 32'd100);
    a_iv = 1'b0; a_or = 1'b0;
    b_iv = 1'b0; b_or = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 20'd42,    1'b1, 1'b0, 1'b0, 20'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 20'd0,     1'b1, 1'b1, 1'b1, 20'd42};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 20'd0,     1'b1, 1'b1, 1'b1, 20'd42};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 20'd0,     1'b1, 1'b0, 1'b0, 20'd0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 20'hBEEF,  1'b1, 1'b1, 1'b1, 20'hBEEF};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 20'hBEEF,  1'b0, 1'b1, 1'b1, 20'hBEEF};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 20'd0,     1'b1, 1'b0, 1'b0, 20'd0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 20'd7,     1'b1, 1'b0, 1'b0, 20'd0};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 20'd0,     1'b1, 1'b0, 1'b1, 20'd0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 20'd0,     1'b1, 1'b1, 1'b1, 20'd7};
    tv[10] = '{1'b1, 1'b1, 1'b0, 20'd8,     1'b1, 1'b1, 1'b1, 20'd7};
    tv[11] = '{1'b0, 1'b0, 1'b0, 20'd0,     1'b1, 1'b1, 1'b1, 20'd8};
    tv[12] = '{1'b0, 1'b1, 1'b0, 20'd0,     1'b1, 1'b1, 1'b1, 20'd8};

    b_cfg = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_a_ov", 32'(a_ov), 32'd0);
    chk("rst_a_ir", 32'(a_ir), 32'd1);
    chk("rst_b_ov", 32'(b_ov), 32'd0);
    chk("rst_b_ir", 32'(b_ir), 32'd1);
    step();

    for (int i = 0; i < 13; i++) begin
      a_iv = tv[i].iv; a_or = tv[i].orr;
      a_cfg = tv[i].cfg; a_id = tv[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_ir", i), 32'(a_ir), 32'(tv[i].e_ir));
      chk($sformatf("vec%0d_ov", i), 32'(a_ov), 32'(tv[i].e_ov));
      if (tv[i].chk_d)
        chk($sformatf("vec%0d_od", i), 32'(a_od), 32'(tv[i].e_od));
      step();
    end
    a_iv = 1'b0; a_or = 1'b0; a_cfg = 1'b0;

    for (int i = 0; i < AD; i++) begin
      a_iv = 1'b1; a_id = AP'(100 + i);
      @(negedge clk);
      chk("fill_ir", 32'(a_ir), 32'd1);
      step();
    end
    a_iv = 1'b1; a_id = AP'(999); a_or = 1'b1;
    @(negedge clk);
    chk("full_ir", 32'(a_ir), 32'd0);
    chk("full_ov", 32'(a_ov), 32'd1);
    chk("drain_d0", 32'(a_od), 32'd100);
    step();
    a_iv = 1'b0;
    for (int i = 1; i < AD; i++) begin
      @(negedge clk);
      chk("drain_ir", 32'(a_ir), 32'd1);
      chk("drain_ov", 32'(a_ov), 32'd1);
      chk("drain_d", 32'(a_od), 32'(100 + i));
      step();
    end
    a_or = 1'b0;
    @(negedge clk);
    chk("drain_empty", 32'(a_ov), 32'd0);
    step();

    a_iv = 1'b1; a_id = AP'(5);
    step();
    step();
    a_iv = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ov", 32'(a_ov), 32'd0);
    chk("midrst_ir", 32'(a_ir), 32'd1);
    step();

    b_iv = 1'b1; b_id = BP'(42);
    step();
    b_iv = 1'b1; b_id = BP'(43); b_or = 1'b1;
    @(negedge clk);
    chk("b_single_ov", 32'(b_ov), 32'd1);
    chk("b_single_od", 32'(b_od), 32'd42);
    chk("b_full_ir", 32'(b_ir), 32'd0);
    step();
    b_iv = 1'b0; b_or = 1'b0;
    @(negedge clk);
    chk("b_pop_ov", 32'(b_ov), 32'd0);
    step();

    do_reset();
    run_random(0, AD, AP, 32'h1234_5678);
    do_reset();
    run_random(1, BD, BP, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
